crc_block_ctrl: RTL and testbench
=================================

CRC_BLOCK_CTRL -- requirements
Module: crc_block_ctrl

Interface
REQ-001 SHALL have parameter IEW, default 2: input beat is 1<<IEW bytes wide (8<<IEW bits).
REQ-002 SHALL have parameter TIMEOUT, default 65536: idle cycles that force-close an open block; legal range 2..2^24.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_tready, output, 1: AXI-stream slave ready.
REQ-006 SHALL have port i_tvalid, input, 1: AXI-stream slave valid.
REQ-007 SHALL have port i_tdata, input, 8<<IEW: slave data, byte lane k = bits [8k+7:8k].
REQ-008 SHALL have port i_tkeep, input, 1<<IEW: per-lane byte-valid; any pattern legal, including all-zero.
REQ-009 SHALL have port o_tready, input, 1: report stream ready.
REQ-010 SHALL have port o_tvalid, output, 1: report stream valid.
REQ-011 SHALL have port o_tdata, output, 8: report byte.
REQ-012 SHALL have port blk_cnt, output, 16: count of reports fully sent, wraps at 0xFFFF->0.

Function
REQ-013 SHALL implement two states: RECV (accept input, update CRC/length) and SEND (emit 8-byte report); i_tready=1 only in RECV, o_tvalid=1 only in SEND.
REQ-014 In RECV, on i_tvalid, SHALL process lanes 0..N-1 in order; each lane with tkeep=1 SHALL update crc via CRC-32 reflected poly 0xEDB88320 (two 4-bit table steps per byte) and increment len.
REQ-015 A kept byte 0xFF SHALL be included in crc and len, close the block, and move to SEND on the next cycle; kept bytes in higher lanes of the same beat SHALL be discarded (not in crc/len).
REQ-016 crc SHALL start at 0xFFFFFFFF and be reported without final inversion.
REQ-017 len SHALL be 31 bits, saturating at 0x7FFFFFFF.
REQ-018 Idle counter SHALL count cycles in RECV with len>0 and no accepted beat carrying a kept byte; at TIMEOUT the block SHALL close and enter SEND with the timeout flag set; it SHALL clear on any accepted kept byte.
REQ-019 With len=0, idle time SHALL never close a block; a beat with tkeep=0 SHALL be accepted and not change crc, len or the idle counter's reset condition.
REQ-020 Report SHALL be 8 bytes, little-endian: bytes 0-3 = {flag, len[30:0]}, bytes 4-7 = crc; byte index advances only on o_tvalid&&o_tready.
REQ-021 o_tdata SHALL stay stable while o_tvalid=1 and o_tready=0.
REQ-022 After byte 7 handshake: blk_cnt increments, crc<=0xFFFFFFFF, len<=0, flag<=0, idle<=0, state<=RECV next cycle; zero bubble beyond that one cycle.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=RECV, crc=0xFFFFFFFF, len=0, flag=0, idle=0, byte index=0, blk_cnt=0; outputs i_tready=1, o_tvalid=0, o_tdata=0x00 the following cycle.
REQ-024 Reset mid-SEND SHALL abandon the partial report without incrementing blk_cnt.

Structure
REQ-025 Shared package SHALL hold CRC_INIT (0xFFFFFFFF), the 16-entry CRC nibble table, TERM_BYTE (0xFF), REPORT_BYTES (8), and the state encoding.
REQ-026 Byte update SHALL be one combinational sub-module, crc32_byte_update (in: crc[31:0], byte[7:0]; out: crc[31:0]), instantiated once per lane in a chain.

Verification
REQ-027 Single beat, IEW=2, tkeep=0001, lane0=0xFF -> report 01 00 00 00 FF FF FF 00; blk_cnt=1.
REQ-028 One beat, tkeep=0111, lanes = 0x00, 0xFF, 0x12 -> 0x12 discarded; report 02 00 00 00 8D 02 24 93.
REQ-029 TIMEOUT=16, beat tkeep=0001 lane0=0x00, then 16 idle cycles -> report 01 00 00 80 72 10 FD 2D.
REQ-030 Report in progress, o_tready low for 5 cycles at byte 2 -> o_tdata holds byte 2, i_tready stays 0, no byte lost or duplicated.
REQ-031 rst pulsed after report byte 3 handshake -> next cycle o_tvalid=0, i_tready=1, blk_cnt=0; a following 0xFF block reports 01 00 00 00 FF FF FF 00.
REQ-032 200 beats with tkeep=0000 and len=0 -> no report emitted, state stays RECV.

Source files
------------

// File: rtl/crc_block_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_block_ctrl_pkg
// Description : Shared constants, CRC-32 nibble table and state encoding for
//               the CRC block controller.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_block_ctrl_pkg;

  // CRC register value at the start of every block (no final inversion applied)
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  // A kept byte with this value closes the current block
  localparam logic [7:0] TERM_BYTE = 8'hFF;

  // Report length in bytes: {flag, len} followed by crc, little-endian
  localparam int REPORT_BYTES = 8;

  // Reflected CRC-32 (poly 0xEDB88320) table indexed by one nibble
  localparam logic [31:0] CRC_NIBBLE_TBL [16] = '{
    32'h0000_0000, 32'h1DB7_1064, 32'h3B6E_20C8, 32'h26D9_30AC,
    32'h76DC_4190, 32'h6B6B_51F4, 32'h4DB2_6158, 32'h5005_713C,
    32'hEDB8_8320, 32'hF00F_9344, 32'hD6D6_A3E8, 32'hCB61_B38C,
    32'h9B64_C2B0, 32'h86D3_D2D4, 32'hA00A_E278, 32'hBDBD_F21C
  };

  // Controller states: accepting input or emitting the report
  typedef enum logic [0:0] {
    ST_RECV = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage : crc_block_ctrl_pkg
`default_nettype wire

// File: rtl/crc32_byte_update.sv
`default_nettype none
// ============================================================================
// Module      : crc32_byte_update
// Description : Combinational reflected CRC-32 update by one byte, done as two
//               4-bit table steps (low nibble first).
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_byte_update
  import crc_block_ctrl_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] crc_o
);

  logic [31:0] w_mid;

  // Low nibble step, then high nibble step
  always_comb begin
    w_mid = (crc_i >> 4) ^ CRC_NIBBLE_TBL[crc_i[3:0] ^ byte_i[3:0]];
    crc_o = (w_mid >> 4) ^ CRC_NIBBLE_TBL[w_mid[3:0] ^ byte_i[7:4]];
  end

endmodule : crc32_byte_update
`default_nettype wire

// File: rtl/crc_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : crc_block_ctrl
// Description : Accumulates CRC-32 and byte length over a stream of keyed
//               bytes, closes a block on a 0xFF byte or an idle timeout, and
//               emits an 8-byte little-endian report {flag,len} + crc.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_block_ctrl
  import crc_block_ctrl_pkg::*;
#(
  parameter int IEW     = 2,
  parameter int TIMEOUT = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  i_tready,
  input  logic                  i_tvalid,
  input  logic [(8<<IEW)-1:0]   i_tdata,
  input  logic [(1<<IEW)-1:0]   i_tkeep,
  input  logic                  o_tready,
  output logic                  o_tvalid,
  output logic [7:0]            o_tdata,
  output logic [15:0]           blk_cnt
);

  localparam int                 LANES     = 1 << IEW;
  localparam int                 IDLE_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam int                 IDX_W     = $clog2(REPORT_BYTES);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(REPORT_BYTES - 1);
  localparam logic [30:0]        LEN_MAX   = '1;

  state_e              state_q, state_d;
  logic [31:0]         crc_q, crc_d;
  logic [30:0]         len_q, len_d;
  logic                flag_q, flag_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         blk_cnt_q, blk_cnt_d;

  logic [LANES-1:0]    w_lane_act;
  logic                w_term;
  logic                w_any_kept;
  logic [IEW:0]        w_kept_cnt;
  logic [31:0]         w_crc_chain [LANES+1];
  logic [31:0]         w_crc_upd   [LANES];
  logic [31:0]         w_len_sum;
  logic [30:0]         w_len_sat;
  logic [31:0]         w_word;

  // Lane scan: a lane counts if kept and no earlier lane of this beat terminated
  always_comb begin
    w_term     = 1'b0;
    w_kept_cnt = '0;
    w_lane_act = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_act[k] = i_tkeep[k] && !w_term;
      if (w_lane_act[k]) begin
        w_kept_cnt = w_kept_cnt + (IEW+1)'(1);
        if (i_tdata[8*k +: 8] == TERM_BYTE) begin
          w_term = 1'b1;
        end
      end
    end
  end

  assign w_any_kept = |i_tkeep;

  // CRC chain across lanes; inactive lanes pass the value through unchanged
  assign w_crc_chain[0] = crc_q;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    crc32_byte_update u_crc_upd (
      .crc_i  (w_crc_chain[k]),
      .byte_i (i_tdata[8*k +: 8]),
      .crc_o  (w_crc_upd[k])
    );
    assign w_crc_chain[k+1] = w_lane_act[k] ? w_crc_upd[k] : w_crc_chain[k];
  end

  // Saturating length: overflow into bit 31 means the 31-bit count is full
  assign w_len_sum = {1'b0, len_q} + {{(31-IEW){1'b0}}, w_kept_cnt};
  assign w_len_sat = w_len_sum[31] ? LEN_MAX : w_len_sum[30:0];

  // Report byte select: bytes 0-3 are {flag,len}, bytes 4-7 are crc
  assign w_word  = idx_q[IDX_W-1] ? crc_q : {flag_q, len_q};
  assign o_tdata = (state_q == ST_SEND) ? w_word[{idx_q[1:0], 3'b000} +: 8] : 8'h00;
  assign blk_cnt = blk_cnt_q;

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    flag_d    = flag_q;
    idle_d    = idle_q;
    idx_d     = idx_q;
    blk_cnt_d = blk_cnt_q;
    i_tready  = 1'b0;
    o_tvalid  = 1'b0;
    case (state_q)
      ST_RECV: begin
        i_tready = 1'b1;
        if (i_tvalid && w_any_kept) begin
          crc_d  = w_crc_chain[LANES];
          len_d  = w_len_sat;
          idle_d = '0;
          if (w_term) begin
            state_d = ST_SEND;
          end
        end else if (len_q != '0) begin
          // An empty block can idle forever; an open one times out
          if (idle_q == IDLE_LAST) begin
            idle_d  = '0;
            flag_d  = 1'b1;
            state_d = ST_SEND;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
      ST_SEND: begin
        o_tvalid = 1'b1;
        if (o_tready) begin
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            blk_cnt_d = blk_cnt_q + 16'd1;
            crc_d     = CRC_INIT;
            len_d     = '0;
            flag_d    = 1'b0;
            idle_d    = '0;
            state_d   = ST_RECV;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RECV;
      crc_q     <= CRC_INIT;
      len_q     <= '0;
      flag_q    <= 1'b0;
      idle_q    <= '0;
      idx_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      flag_q    <= flag_d;
      idle_q    <= idle_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

endmodule : crc_block_ctrl
`default_nettype wire

// File: tb/tb_crc_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_block_ctrl
// Description : Directed self-checking bench for crc_block_ctrl (IEW=2,
//               TIMEOUT=16) with hand-computed report values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_crc_block_ctrl;

  localparam int IEW     = 2;
  localparam int TIMEOUT = 16;

  // Reports as 64-bit words, byte 0 in bits [7:0]
  localparam logic [63:0] REP_FF   = 64'h00FF_FFFF_0000_0001; // 01 00 00 00 FF FF FF 00
  localparam logic [63:0] REP_00FF = 64'h9324_028D_0000_0002; // 02 00 00 00 8D 02 24 93
  localparam logic [63:0] REP_TMO  = 64'h2DFD_1072_8000_0001; // 01 00 00 80 72 10 FD 2D

  logic        clk = 1'b0;
  logic        rst;
  logic        i_tready;
  logic        i_tvalid;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;
  logic        o_tready;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic [15:0] blk_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_blk = 16'd0;

  crc_block_ctrl #(.IEW(IEW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_tready (i_tready),
    .i_tvalid (i_tvalid),
    .i_tdata  (i_tdata),
    .i_tkeep  (i_tkeep),
    .o_tready (o_tready),
    .o_tvalid (o_tvalid),
    .o_tdata  (o_tdata),
    .blk_cnt  (blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; called just after a rising edge with the DUT in RECV
  task automatic send_beat(input logic [3:0] keep, input logic [31:0] data);
    i_tvalid = 1'b1;
    i_tkeep  = keep;
    i_tdata  = data;
    tick();
    i_tvalid = 1'b0;
    i_tkeep  = 4'h0;
    i_tdata  = 32'h0;
  endtask

  // Gather nbytes report bytes; optional 5-cycle stall before byte stall_idx
  task automatic collect(input int nbytes, input int stall_idx,
                         output logic [63:0] rep, output int got);
    int   cyc;
    logic stalled;
    logic [7:0] held;
    rep     = '0;
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    while (got < nbytes && cyc < 200) begin
      if (o_tvalid) begin
        if (got == stall_idx && !stalled) begin
          stalled  = 1'b1;
          o_tready = 1'b0;
          held     = o_tdata;
          for (int s = 0; s < 5; s++) begin
            tick();
            checks++;
            if (o_tdata !== held || i_tready !== 1'b0 || o_tvalid !== 1'b1) begin
              errors++;
              $display("FAIL stall_hold cyc %0d: o_tdata=%h (want %h) i_tready=%b (want 0) o_tvalid=%b (want 1)",
                       s, o_tdata, held, i_tready, o_tvalid);
            end
          end
        end
        o_tready = 1'b1;
        rep[8*got +: 8] = o_tdata;
        got++;
      end else begin
        o_tready = 1'b0;
      end
      tick();
      cyc++;
    end
    o_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (i_tready !== 1'b1 || o_tvalid !== 1'b0 || o_tdata !== 8'h00 || blk_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: i_tready=%b o_tvalid=%b o_tdata=%h blk_cnt=%0d, want 1 0 00 0",
               i_tready, o_tvalid, o_tdata, blk_cnt);
    end
    rst = 1'b0;
    exp_blk = 16'd0;
  endtask

  task automatic test_term_single();
    logic [63:0] rep;
    int got;
    send_beat(4'b0001, 32'h0000_00FF);
    checks++;
    if (o_tvalid !== 1'b1 || i_tready !== 1'b0) begin
      errors++;
      $display("FAIL term_enter_send: o_tvalid=%b i_tready=%b, want 1 0", o_tvalid, i_tready);
    end
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (got !== 8 || rep !== REP_FF) begin
      errors++;
      $display("FAIL term_single: report %h (%0d bytes), want %h (8 bytes)", rep, got, REP_FF);
    end
    checks++;
    if (blk_cnt !== exp_blk || i_tready !== 1'b1 || o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL term_single_after: blk_cnt=%0d i_tready=%b o_tvalid=%b, want %0d 1 0",
               blk_cnt, i_tready, o_tvalid, exp_blk);
    end
  endtask

  task automatic test_discard();
    logic [63:0] rep;
    int got;
    // lanes 0..2 = 00, FF, 12; 0x12 follows the terminator and is dropped
    send_beat(4'b0111, 32'h0012_FF00);
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (got !== 8 || rep !== REP_00FF) begin
      errors++;
      $display("FAIL discard: report %h (%0d bytes), want %h", rep, got, REP_00FF);
    end
  endtask

  task automatic test_multi_beat();
    logic [63:0] rep;
    int got;
    // 0x00 in lane 1 of one beat, 0xFF in lane 2 of the next
    send_beat(4'b0010, 32'h1111_0011);
    checks++;
    if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
      errors++;
      $display("FAIL multi_open: o_tvalid=%b i_tready=%b, want 0 1", o_tvalid, i_tready);
    end
    send_beat(4'b0100, 32'h22FF_2222);
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (got !== 8 || rep !== REP_00FF || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL multi_beat: report %h blk_cnt=%0d, want %h blk_cnt=%0d", rep, blk_cnt, REP_00FF, exp_blk);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] rep;
    int got;
    send_beat(4'b0001, 32'h0000_0000);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (o_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: o_tvalid=%b after %0d idle cycles, want 0", o_tvalid, TIMEOUT - 1);
    end
    tick();
    checks++;
    if (o_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: o_tvalid=%b after %0d idle cycles, want 1", o_tvalid, TIMEOUT);
    end
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (got !== 8 || rep !== REP_TMO) begin
      errors++;
      $display("FAIL timeout_report: report %h, want %h", rep, REP_TMO);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rep;
    int got;
    send_beat(4'b1000, 32'hFF00_0000);
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (rep !== REP_FF || i_tready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: report %h i_tready=%b, want %h 1", rep, i_tready, REP_FF);
    end
    // lane 0 terminates; the FF in lane 3 must not count
    send_beat(4'b1001, 32'hFF00_00FF);
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (rep !== REP_FF || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL b2b_second: report %h blk_cnt=%0d, want %h %0d", rep, blk_cnt, REP_FF, exp_blk);
    end
  endtask

  task automatic test_stall();
    logic [63:0] rep;
    int got;
    send_beat(4'b0001, 32'h0000_00FF);
    collect(8, 2, rep, got);
    exp_blk++;
    checks++;
    if (got !== 8 || rep !== REP_FF || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL stall_report: report %h (%0d bytes) blk_cnt=%0d, want %h 8 %0d",
               rep, got, blk_cnt, REP_FF, exp_blk);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [63:0] rep;
    int got;
    send_beat(4'b0011, 32'h0000_FF00);
    collect(4, -1, rep, got);
    checks++;
    if (rep[31:0] !== REP_00FF[31:0]) begin
      errors++;
      $display("FAIL partial_report: first bytes %h, want %h", rep[31:0], REP_00FF[31:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_blk = 16'd0;
    checks++;
    if (o_tvalid !== 1'b0 || i_tready !== 1'b1 || blk_cnt !== 16'd0 || o_tdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_send: o_tvalid=%b i_tready=%b blk_cnt=%0d o_tdata=%h, want 0 1 0 00",
               o_tvalid, i_tready, blk_cnt, o_tdata);
    end
    send_beat(4'b0001, 32'h0000_00FF);
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (rep !== REP_FF || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL after_reset_report: report %h blk_cnt=%0d, want %h %0d", rep, blk_cnt, REP_FF, exp_blk);
    end
  endtask

  task automatic test_empty_beats();
    logic [63:0] rep;
    int got;
    int bad;
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      i_tvalid = 1'b1;
      i_tkeep  = 4'b0000;
      i_tdata  = 32'hFFFF_FFFF;
      tick();
      if (o_tvalid !== 1'b0 || i_tready !== 1'b1) bad++;
    end
    i_tvalid = 1'b0;
    i_tdata  = 32'h0;
    repeat (2 * TIMEOUT) begin
      tick();
      if (o_tvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL empty_beats: %0d cycles left RECV, want 0", bad);
    end
    send_beat(4'b0001, 32'h0000_00FF);
    collect(8, -1, rep, got);
    exp_blk++;
    checks++;
    if (rep !== REP_FF || blk_cnt !== exp_blk) begin
      errors++;
      $display("FAIL empty_then_term: report %h blk_cnt=%0d, want %h %0d", rep, blk_cnt, REP_FF, exp_blk);
    end
  endtask

  initial begin
    rst      = 1'b1;
    i_tvalid = 1'b0;
    i_tkeep  = 4'h0;
    i_tdata  = 32'h0;
    o_tready = 1'b0;
    #1;
    test_reset();
    test_term_single();
    test_discard();
    test_multi_beat();
    test_timeout();
    test_back_to_back();
    test_stall();
    test_reset_mid_send();
    test_empty_beats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule : tb_crc_block_ctrl
`default_nettype wire
